// File: rtl/spi_pkg.sv
// Shared types and SPI mode encodings for the SPI slave.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2
  } spi_slave_state_t;

  // {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE_0 = 2'b00;
  localparam logic [1:0] SPI_MODE_1 = 2'b01;
  localparam logic [1:0] SPI_MODE_2 = 2'b10;
  localparam logic [1:0] SPI_MODE_3 = 2'b11;

endpackage

// File: rtl/spi_input_sync.sv
// Multi-bit synchronizer with per-bit reset value and registered rise/fall strobes.
// lvl_o is the delayed copy used for edge detection, so it lines up with rise_o/fall_o.
module spi_input_sync #(
  parameter int                 WIDTH       = 3,
  parameter int                 SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0]   RESET_VAL   = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] lvl_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [WIDTH-1:0] chain_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) chain_q[i] <= RESET_VAL;
      prev_q <= RESET_VAL;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      chain_q[0] <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) chain_q[i] <= chain_q[i-1];
      prev_q <= chain_q[SYNC_STAGES-1];
      rise_q <= chain_q[SYNC_STAGES-1] & ~prev_q;
      fall_q <= ~chain_q[SYNC_STAGES-1] & prev_q;
    end
  end

  assign lvl_o  = prev_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave.sv
// Oversampling SPI slave, all four CPOL/CPHA modes, MSB-first frames.
// Optional build macro SPI_SLAVE_MISO_OE_EN adds o_spi_miso_oe for a shared MISO bus.
module spi_slave
  import spi_pkg::*;
#(
  parameter int SPI_DATA_WIDTH = 32,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_clock_polarity,
  input  logic                      i_clock_phase,
  input  logic [SPI_DATA_WIDTH-1:0] i_data_in,
  input  logic                      i_load,
  output logic [SPI_DATA_WIDTH-1:0] o_data_out,
  output logic                      o_valid,
  output logic                      o_busy,
  input  logic                      i_spi_cs_n,
  input  logic                      i_spi_clock,
  input  logic                      i_spi_mosi,
  output logic                      o_spi_miso
`ifdef SPI_SLAVE_MISO_OE_EN
  ,
  output logic                      o_spi_miso_oe
`endif
);

  localparam int W       = SPI_DATA_WIDTH;
  localparam int CNT_W   = $clog2(SPI_DATA_WIDTH + 1);
  localparam int FLUSH_W = $clog2(SYNC_STAGES + 3);
  localparam logic [FLUSH_W-1:0] FLUSH_DONE = FLUSH_W'(SYNC_STAGES + 2);

  logic [2:0] pins_lvl, pins_rise, pins_fall;

  spi_input_sync #(
    .WIDTH      (3),
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (3'b100)
  ) u_sync (
    .clk_i (i_clock),
    .rst_i (i_reset),
    .d_i   ({i_spi_cs_n, i_spi_clock, i_spi_mosi}),
    .lvl_o (pins_lvl),
    .rise_o(pins_rise),
    .fall_o(pins_fall)
  );

  logic cs_lvl, cs_fall, sclk_rise, sclk_fall, mosi_lvl;
  logic unused_edges;
  assign cs_lvl       = pins_lvl[2];
  assign cs_fall      = pins_fall[2];
  assign sclk_rise    = pins_rise[1];
  assign sclk_fall    = pins_fall[1];
  assign mosi_lvl     = pins_lvl[0];
  assign unused_edges = ^{pins_rise[2], pins_lvl[1], pins_rise[0], pins_fall[0]};

  spi_slave_state_t    state_q;
  logic [FLUSH_W-1:0]  flush_q;
  logic                cpol_q, cpha_q;
  logic [W-1:0]        hold_q, tx_q, rx_q, data_out_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                valid_q, miso_q, busy_q;

  logic                lead_d, trail_d, sample_d, shift_d;
  logic [W-1:0]        rx_next_d, tx_word_d;

  always_comb begin
    lead_d    = cpol_q ? sclk_fall : sclk_rise;
    trail_d   = cpol_q ? sclk_rise : sclk_fall;
    sample_d  = cpha_q ? trail_d : lead_d;
    shift_d   = cpha_q ? lead_d : trail_d;
    rx_next_d = {rx_q[W-2:0], mosi_lvl};
    tx_word_d = i_load ? i_data_in : hold_q;
  end

  // Reset lands in DRAIN: the CS synchronizer restarts at 1, so a frame already
  // in progress would otherwise look like a fresh CS fall once the chain flushes.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= DRAIN;
      flush_q    <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      hold_q     <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      cnt_q      <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      miso_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      busy_q  <= ~cs_lvl;
      if (flush_q != FLUSH_DONE) flush_q <= flush_q + FLUSH_W'(1);
      if (i_load) hold_q <= i_data_in;

      case (state_q)
        IDLE: begin
          miso_q <= 1'b0;
          if (cs_fall) begin
            cpol_q  <= i_clock_polarity;
            cpha_q  <= i_clock_phase;
            cnt_q   <= '0;
            rx_q    <= '0;
            state_q <= SHIFT;
            if (i_clock_phase) begin
              tx_q <= tx_word_d;
            end else begin
              miso_q <= tx_word_d[W-1];
              tx_q   <= {tx_word_d[W-2:0], 1'b0};
            end
          end
        end

        SHIFT: begin
          if (cs_lvl) begin
            miso_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            if (shift_d) begin
              miso_q <= tx_q[W-1];
              tx_q   <= {tx_q[W-2:0], 1'b0};
            end
            if (sample_d) begin
              rx_q  <= rx_next_d;
              cnt_q <= cnt_q + CNT_W'(1);
              if (cnt_q == CNT_W'(W - 1)) begin
                data_out_q <= rx_next_d;
                valid_q    <= 1'b1;
                miso_q     <= 1'b0;
                state_q    <= DRAIN;
              end
            end
          end
        end

        DRAIN: begin
          miso_q <= 1'b0;
          if (cs_lvl && (flush_q == FLUSH_DONE)) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_data_out = data_out_q;
  assign o_valid    = valid_q;
  assign o_busy     = busy_q;
  assign o_spi_miso = miso_q;
`ifdef SPI_SLAVE_MISO_OE_EN
  assign o_spi_miso_oe = busy_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a bit-banged SPI master drives frames, a scoreboard
// queue holds expected received words and a monitor checks them on each o_valid.
module tb_spi_slave;
  import spi_pkg::*;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_clock_polarity = 1'b0;
  logic        i_clock_phase = 1'b0;
  logic [31:0] i_data_in = '0;
  logic        i_load = 1'b0;
  logic [31:0] o_data_out;
  logic        o_valid;
  logic        o_busy;
  logic        spi_cs_n = 1'b1;
  logic        spi_clk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
`ifdef SPI_SLAVE_MISO_OE_EN
  logic        spi_miso_oe;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic        prev_v = 1'b0;

  always #5 clk = ~clk;

  spi_slave dut (
    .i_clock         (clk),
    .i_reset         (i_reset),
    .i_clock_polarity(i_clock_polarity),
    .i_clock_phase   (i_clock_phase),
    .i_data_in       (i_data_in),
    .i_load          (i_load),
    .o_data_out      (o_data_out),
    .o_valid         (o_valid),
    .o_busy          (o_busy),
    .i_spi_cs_n      (spi_cs_n),
    .i_spi_clock     (spi_clk),
    .i_spi_mosi      (spi_mosi),
    .o_spi_miso      (spi_miso)
`ifdef SPI_SLAVE_MISO_OE_EN
    ,
    .o_spi_miso_oe   (spi_miso_oe)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] w);
    i_data_in = w;
    i_load = 1'b1;
    wait_cyc(1);
    i_load = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (o_valid) begin
      chk("valid_single_cycle", {63'd0, prev_v}, 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got data %h expected no valid", o_data_out);
      end else begin
        chk("rx_word", {32'd0, o_data_out}, {32'd0, exp_q.pop_front()});
      end
    end
    prev_v = o_valid;
  end

  task automatic frame(input logic [1:0] mode, input logic [63:0] mbits, input int nbits,
                       input int rst_bit, input logic do_load, input logic [31:0] lw,
                       output logic [63:0] rx, output int unstable);
    logic cpol, cpha, smp;
    cpol = mode[1];
    cpha = mode[0];
    rx = '0;
    unstable = 0;
    smp = 1'b0;
    wait_cyc(1);
    i_clock_polarity = cpol;
    i_clock_phase = cpha;
    spi_clk = cpol;
    wait_cyc(10);
    spi_mosi = mbits[63];
    spi_cs_n = 1'b0;
    wait_cyc(3);
    if (do_load) load_word(lw);
    else wait_cyc(1);
    wait_cyc(6);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_bit) begin
        i_reset = 1'b1;
        wait_cyc(1);
        chk("rst_mid_valid", {63'd0, o_valid}, 64'd0);
        chk("rst_mid_busy", {63'd0, o_busy}, 64'd0);
        chk("rst_mid_miso", {63'd0, spi_miso}, 64'd0);
        chk("rst_mid_data", {32'd0, o_data_out}, 64'd0);
        wait_cyc(1);
        i_reset = 1'b0;
        wait_cyc(2);
      end
      if (i == 5) chk("busy_mid_frame", {63'd0, o_busy}, 64'd1);
      spi_clk = ~cpol;
      if (cpha) spi_mosi = mbits[63-i];
      else begin
        smp = spi_miso;
        rx = {rx[62:0], smp};
      end
      wait_cyc(HALF);
      if (!cpha && i != 31 && spi_miso !== smp) unstable++;
      spi_clk = cpol;
      if (!cpha) spi_mosi = (i < 63) ? mbits[62-i] : 1'b0;
      else begin
        smp = spi_miso;
        rx = {rx[62:0], smp};
      end
      wait_cyc(HALF);
      if (cpha && i != 31 && spi_miso !== smp) unstable++;
    end
    spi_cs_n = 1'b1;
    wait_cyc(12);
    chk("busy_after_frame", {63'd0, o_busy}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rx;
    int unst;

    wait_cyc(5);
    chk("reset_data", {32'd0, o_data_out}, 64'd0);
    chk("reset_valid", {63'd0, o_valid}, 64'd0);
    chk("reset_busy", {63'd0, o_busy}, 64'd0);
    chk("reset_miso", {63'd0, spi_miso}, 64'd0);
    i_reset = 1'b0;
    wait_cyc(20);

    // Mode 0 basic
    load_word(32'h1234_5678);
    exp_q.push_back(32'hA5A5_0F0F);
    frame(SPI_MODE_0, {32'hA5A5_0F0F, 32'h0}, 32, -1, 1'b0, 32'h0, rx, unst);
    chk("m0_miso_word", {32'd0, rx[31:0]}, {32'd0, 32'h1234_5678});
    chk("m0_miso_stable", 64'(unst), 64'd0);

    // Modes 1..3, word resent from the holding register each time
    load_word(32'hDEAD_BEEF);
    exp_q.push_back(32'hDEAD_BEEF);
    frame(SPI_MODE_1, {32'hDEAD_BEEF, 32'h0}, 32, -1, 1'b0, 32'h0, rx, unst);
    chk("m1_miso_word", {32'd0, rx[31:0]}, {32'd0, 32'hDEAD_BEEF});
    chk("m1_miso_stable", 64'(unst), 64'd0);
    exp_q.push_back(32'hDEAD_BEEF);
    frame(SPI_MODE_2, {32'hDEAD_BEEF, 32'h0}, 32, -1, 1'b0, 32'h0, rx, unst);
    chk("m2_miso_word", {32'd0, rx[31:0]}, {32'd0, 32'hDEAD_BEEF});
    chk("m2_miso_stable", 64'(unst), 64'd0);
    exp_q.push_back(32'hDEAD_BEEF);
    frame(SPI_MODE_3, {32'hDEAD_BEEF, 32'h0}, 32, -1, 1'b0, 32'h0, rx, unst);
    chk("m3_miso_word", {32'd0, rx[31:0]}, {32'd0, 32'hDEAD_BEEF});
    chk("m3_miso_stable", 64'(unst), 64'd0);

    // Aborted frame after 17 bits, then a full one
    frame(SPI_MODE_0, {32'h0BAD_F00D, 32'h0}, 17, -1, 1'b0, 32'h0, rx, unst);
    chk("abort_data_kept", {32'd0, o_data_out}, {32'd0, 32'hDEAD_BEEF});
    exp_q.push_back(32'h1357_9BDF);
    frame(SPI_MODE_0, {32'h1357_9BDF, 32'h0}, 32, -1, 1'b0, 32'h0, rx, unst);
    chk("post_abort_miso", {32'd0, rx[31:0]}, {32'd0, 32'hDEAD_BEEF});

    // 40 SCLK cycles in one frame
    exp_q.push_back(32'h0F1E_2D3C);
    frame(SPI_MODE_0, {32'h0F1E_2D3C, 8'hFF, 24'h0}, 40, -1, 1'b0, 32'h0, rx, unst);
    chk("long_miso_word", {32'd0, rx[39:8]}, {32'd0, 32'hDEAD_BEEF});
    chk("long_miso_drain", {56'd0, rx[7:0]}, 64'd0);
    chk("long_miso_stable", 64'(unst), 64'd0);

    // Reset pulsed mid-frame with CS low
    frame(SPI_MODE_0, {32'hCAFE_F00D, 32'h0}, 32, 10, 1'b0, 32'h0, rx, unst);
    chk("rst_frame_data", {32'd0, o_data_out}, 64'd0);
    load_word(32'h55AA_55AA);
    exp_q.push_back(32'h89AB_CDEF);
    frame(SPI_MODE_3, {32'h89AB_CDEF, 32'h0}, 32, -1, 1'b0, 32'h0, rx, unst);
    chk("post_rst_miso", {32'd0, rx[31:0]}, {32'd0, 32'h55AA_55AA});

    // Load coinciding with internal frame start, then retransmit
    load_word(32'h1111_1111);
    exp_q.push_back(32'h2468_ACE0);
    frame(SPI_MODE_1, {32'h2468_ACE0, 32'h0}, 32, -1, 1'b1, 32'h0000_00FF, rx, unst);
    chk("load_at_start_miso", {32'd0, rx[31:0]}, {32'd0, 32'h0000_00FF});
    exp_q.push_back(32'hFFFF_0000);
    frame(SPI_MODE_0, {32'hFFFF_0000, 32'h0}, 32, -1, 1'b0, 32'h0, rx, unst);
    chk("resend_miso", {32'd0, rx[31:0]}, {32'd0, 32'h0000_00FF});

    wait_cyc(20);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

Single-clock SPI slave: the responder end of the team's SPI link, for loopback testing of the master core and for FPGA-hosted peripherals. It oversamples the SPI pins on `i_clock` and supports all four CPOL/CPHA modes with MSB-first frames of `SPI_DATA_WIDTH` bits. It exposes a parallel transmit-load / receive-valid interface to user logic.

## Interface
- `SPI_DATA_WIDTH`, 32, bits per frame; ≥ 2.
- `SYNC_STAGES`, 2, synchronizer flops on `i_spi_cs_n`, `i_spi_clock` and `i_spi_mosi`; ≥ 2.
- `i_clock`  in  1  system clock (100 MHz).
- `i_reset`  in  1  **synchronous, active-high** reset.
- `i_clock_polarity`  in  1  CPOL; latched at frame start.
- `i_clock_phase`  in  1  CPHA; latched at frame start.
- `i_data_in`  in  `SPI_DATA_WIDTH`  word for the next frame on MISO.
- `i_load`  in  1  captures `i_data_in` into the TX holding register.
- `o_data_out`  out  `SPI_DATA_WIDTH`  last complete word received on MOSI.
- `o_valid`  out  1  one-cycle pulse; `o_data_out` updated this cycle.
- `o_busy`  out  1  high while a frame is in progress (synced CS low).
- `i_spi_cs_n`  in  1  chip select, active low, asynchronous.
- `i_spi_clock`  in  1  SPI clock, asynchronous.
- `i_spi_mosi`  in  1  master out.
- `o_spi_miso`  out  1  slave out.

## Operation
- Synchronizer reset values: `i_spi_cs_n` chain 1; `i_spi_clock` and `i_spi_mosi` chains 0. The edge detector compares the last synchronized stage with one extra flop.
- Leading SCLK edge: transition away from latched CPOL. Trailing edge: transition back to it.
- CPHA=0: sample MOSI on leading edges; shift MISO on trailing edges. The MSB is on MISO from frame start.
- CPHA=1: shift MISO on leading edges (the first leading edge presents the MSB); sample on trailing edges.
- TX holding register: written by `i_load` in any cycle; reset 0. It is copied to the TX shift register at frame start. If a load coincides with frame start, the new `i_data_in` is used. With no new load, the previous word is resent.
- States:
  - **IDLE**: on a synced CS falling edge, latch CPOL/CPHA, load the TX shift register, clear the bit counter, go to SHIFT.
  - **SHIFT**: count samples. On sample number `SPI_DATA_WIDTH`, write the RX shift result to `o_data_out`, pulse `o_valid`, go to DRAIN.
  - **DRAIN**: ignore further SCLK edges and drive MISO 0. On synced CS high, go to IDLE.
- CS rising in SHIFT before the full bit count: the frame is aborted, with no `o_valid` and `o_data_out` unchanged; go to IDLE.
- CS high is checked before SCLK edges in the same cycle.
- `o_spi_miso` is 0 in IDLE and DRAIN.
- Reset while CS is low: enter DRAIN. The remainder of the frame is ignored until CS returns high.

## Timing
- Reset values: `o_data_out`=0, `o_valid`=0, `o_busy`=0, `o_spi_miso`=0.
- Pin edge to internal edge detect: `SYNC_STAGES`+1 cycles.
- Last sampling pin edge to `o_valid`: `SYNC_STAGES`+2 cycles.
- Shift pin edge to `o_spi_miso` change: `SYNC_STAGES`+2 cycles.
- `o_busy` rises `SYNC_STAGES`+2 cycles after the CS pin falls, and falls the same delay after CS rises.
- Requirements on the master:
  - SCLK half-period ≥ `SYNC_STAGES`+4 `i_clock` cycles.
  - CS-fall to first SCLK edge ≥ `SYNC_STAGES`+4 cycles.
- `o_valid` is never asserted on two consecutive cycles.

## Configuration
- `SPI_SLAVE_MISO_OE_EN` defined:
  - adds output port `o_spi_miso_oe` (1 bit, reset 0);
  - `o_spi_miso_oe` is high exactly while `o_busy` is high, for a top-level tristate buffer on a shared MISO bus.
- Not defined: no `o_spi_miso_oe` port; `o_spi_miso` is always driven.

## Structure
- Package `spi_pkg`:
  - `spi_slave_state_t` enum (IDLE, SHIFT, DRAIN);
  - mode constants `SPI_MODE_0`..`SPI_MODE_3` as 2-bit {CPOL, CPHA}.
- Sub-module `spi_input_sync`: a parameterized `SYNC_STAGES` synchronizer with per-bit reset value, plus rise/fall edge outputs. Instantiated once for the three SPI inputs.
- Top level holds the FSM, bit counter (`$clog2(SPI_DATA_WIDTH+1)` bits), TX/RX shift registers and TX holding register.

## Test plan
- Mode 0, master sends 32'hA5A5_0F0F, holding register 32'h1234_5678 → `o_data_out`=32'hA5A5_0F0F with one `o_valid` pulse; master receives 32'h1234_5678.
- Modes 1, 2, 3, each with 32'hDEAD_BEEF in both directions → both words are exact; MISO changes only on the correct edge.
- CS raised after 17 bits → no `o_valid`, `o_data_out` unchanged; the next full frame receives correctly.
- 40 SCLK cycles in one frame → one `o_valid` after bit 32; MISO is 0 for bits 33–40.
- `i_reset` pulsed mid-frame with CS held low → outputs are at reset values; no `o_valid` for that frame; the following frame is correct.
- `i_load` in the same cycle as internal frame start with 32'h0000_00FF → that word is transmitted. The next frame, with no load, retransmits 32'h0000_00FF.
